// File: rtl/event_encoder83_pkg.sv
// event_encoder83_pkg
// Shared constants and types for the 8-line event encoder:
//   EV_LINES    number of request lines
//   EV_CODE_W   width of the encoded line index
//   EV_CODE_RST code presented while in reset
//   ev_onehot   expands an index into a one-hot line mask
package event_encoder83_pkg;

  localparam int EV_LINES  = 8;
  localparam int EV_CODE_W = 3;

  typedef logic [EV_LINES-1:0]  ev_vec_t;
  typedef logic [EV_CODE_W-1:0] ev_code_t;

  localparam ev_code_t EV_CODE_RST = 3'b000;

  function automatic ev_vec_t ev_onehot(input ev_code_t code);
    return ev_vec_t'(1) << code;
  endfunction

endpackage

// File: rtl/event_encoder83_if.sv
// event_encoder83_if
// Valid/ready channel that carries encoded line indices to the consumer.
//   out_valid  producer has an undelivered index on out_code
//   out_code   binary line index, bit 2 is the MSB
//   out_ready  consumer takes out_code when out_valid is also high
// Modports: master = encoder side, slave = consumer side.
interface event_encoder83_if;
  import event_encoder83_pkg::*;

  logic     out_valid;
  ev_code_t out_code;
  logic     out_ready;

  modport master (output out_valid, output out_code, input out_ready);
  modport slave  (input out_valid, input out_code, output out_ready);

endinterface

// File: rtl/event_encoder83_prio_enc8.sv
// prio_enc8
// Combinational fixed-priority encoder for an 8-bit vector.
//   vec  input vector
//   idx  index of the winning set bit (EV_CODE_RST when vec is zero)
//   any  high when vec is non-zero
// HIGH_FIRST=1 gives bit 7 top priority, HIGH_FIRST=0 gives bit 0 top priority.
module prio_enc8
  import event_encoder83_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  ev_vec_t  vec,
  output ev_code_t idx,
  output logic     any
);

  // The scan runs from lowest to highest priority so the last hit wins.
  always_comb begin
    idx = EV_CODE_RST;
    any = |vec;
    if (HIGH_FIRST) begin
      for (int i = 0; i < EV_LINES; i++) begin
        if (vec[i]) idx = ev_code_t'(i);
      end
    end else begin
      for (int i = EV_LINES - 1; i >= 0; i--) begin
        if (vec[i]) idx = ev_code_t'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder83.sv
// event_encoder83
// Collects event requests into sticky pending bits, picks the winner by fixed
// priority and delivers its 3-bit index over a valid/ready channel. Each
// index is delivered exactly once.
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request lines, a 1 sets the matching pending bit
//   ovf_clr   synchronous clear of the overflow flag
//   pending   registered pending bits
//   overflow  sticky: a request hit a line that was already pending
//   out_if    master side of the index channel
// Every output is taken straight from a flop.
module event_encoder83
  import event_encoder83_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  ev_vec_t               req,
  input  logic                  ovf_clr,
  output ev_vec_t               pending,
  output logic                  overflow,
  event_encoder83_if.master     out_if
);

  ev_vec_t  pending_q, pending_d;
  ev_code_t out_code_q, out_code_d;
  logic     out_valid_q, out_valid_d;
  logic     overflow_q, overflow_d;

  ev_code_t win;
  logic     win_any;
  logic     accept;
  logic     load;
  ev_vec_t  clear_mask;

  prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_prio (
    .vec (pending_q),
    .idx (win),
    .any (win_any)
  );

  always_comb begin
    accept      = out_valid_q & out_if.out_ready;
    // The output slot is free either when empty or when its code leaves now.
    load        = win_any & (~out_valid_q | out_if.out_ready);
    clear_mask  = load ? ev_onehot(win) : '0;

    // A fresh request on the line being cleared keeps it pending.
    pending_d   = (pending_q & ~clear_mask) | req;

    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_code_d  = win;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // A new overflow event takes precedence over the clear.
    overflow_d = overflow_q;
    if (|(req & pending_q & ~clear_mask)) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_code_q  <= EV_CODE_RST;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pending          = pending_q;
  assign overflow         = overflow_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_code  = out_code_q;

endmodule

// File: tb/tb_event_encoder83.sv
// tb_event_encoder83
// Two encoders (HIGH_FIRST=1 and HIGH_FIRST=0) share the same stimulus.
// The stimulus pushes expected codes into one queue per instance; a monitor
// pops and compares on every accepted transfer. Register state is checked
// directly at fixed points of the directed sequence.
module tb_event_encoder83;
  import event_encoder83_pkg::*;

  logic    clk;
  logic    rst_n;
  ev_vec_t req;
  logic    out_ready;
  logic    ovf_clr;

  ev_vec_t pend_hi, pend_lo;
  logic    ovf_hi, ovf_lo;

  event_encoder83_if if_hi();
  event_encoder83_if if_lo();

  assign if_hi.out_ready = out_ready;
  assign if_lo.out_ready = out_ready;

  event_encoder83 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ovf_clr  (ovf_clr),
    .pending  (pend_hi),
    .overflow (ovf_hi),
    .out_if   (if_hi)
  );

  event_encoder83 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ovf_clr  (ovf_clr),
    .pending  (pend_lo),
    .overflow (ovf_lo),
    .out_if   (if_lo)
  );

  int checks   = 0;
  int failures = 0;

  ev_code_t exp_hi[$];
  ev_code_t exp_lo[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input ev_code_t c_hi, input ev_code_t c_lo);
    exp_hi.push_back(c_hi);
    exp_lo.push_back(c_lo);
  endtask

  // Scoreboard monitor: a transfer happens on the next edge when valid and
  // ready are both high, so sample them mid-cycle.
  always @(negedge clk) begin
    if (rst_n && if_hi.out_valid && out_ready) begin
      checks++;
      if (exp_hi.size() == 0) begin
        failures++;
        $display("FAIL sb_hi: unexpected code %0d delivered at %0t", if_hi.out_code, $time);
      end else begin
        ev_code_t e;
        e = exp_hi.pop_front();
        if (if_hi.out_code !== e) begin
          failures++;
          $display("FAIL sb_hi: got code %0d expected %0d at %0t", if_hi.out_code, e, $time);
        end
      end
    end
    if (rst_n && if_lo.out_valid && out_ready) begin
      checks++;
      if (exp_lo.size() == 0) begin
        failures++;
        $display("FAIL sb_lo: unexpected code %0d delivered at %0t", if_lo.out_code, $time);
      end else begin
        ev_code_t e;
        e = exp_lo.pop_front();
        if (if_lo.out_code !== e) begin
          failures++;
          $display("FAIL sb_lo: got code %0d expected %0d at %0t", if_lo.out_code, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset: values must appear with no clock edge.
    #1;
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    chk("rst_valid_noclk", 32'(if_hi.out_valid), 32'd0);
    chk("rst_code_noclk",  32'(if_hi.out_code),  32'd0);
    chk("rst_pend_noclk",  32'(pend_hi),         32'h00);
    chk("rst_ovf_noclk",   32'(ovf_hi),          32'd0);
    chk("rst_pend_lo",     32'(pend_lo),         32'h00);
    step();
    step();
    chk("rst_valid_clk", 32'(if_hi.out_valid), 32'd0);
    chk("rst_pend_clk",  32'(pend_hi),         32'h00);
    chk("rst_ovf_clk",   32'(ovf_hi),          32'd0);
    req   = 8'h00;
    rst_n = 1'b1;
    step();

    // Single event on line 5.
    out_ready = 1'b1;
    req       = 8'h20;
    push_both(3'd5, 3'd5);
    step();
    chk("single_pend1",  32'(pend_hi),         32'h20);
    chk("single_valid1", 32'(if_hi.out_valid), 32'd0);
    req = 8'h00;
    step();
    chk("single_valid2", 32'(if_hi.out_valid), 32'd1);
    chk("single_code2",  32'(if_hi.out_code),  32'd5);
    chk("single_pend2",  32'(pend_hi),         32'h00);
    step();
    chk("single_valid3", 32'(if_hi.out_valid), 32'd0);

    // Priority drain of 0x91 in both orders, no bubbles.
    req = 8'h91;
    push_both(3'd7, 3'd0);
    push_both(3'd4, 3'd4);
    push_both(3'd0, 3'd7);
    step();
    req = 8'h00;
    chk("drain_pend_hi", 32'(pend_hi), 32'h91);
    chk("drain_pend_lo", 32'(pend_lo), 32'h91);
    step();
    chk("drain_c1_hi",    32'(if_hi.out_code), 32'd7);
    chk("drain_c1_lo",    32'(if_lo.out_code), 32'd0);
    chk("drain_p1_hi",    32'(pend_hi),        32'h11);
    chk("drain_p1_lo",    32'(pend_lo),        32'h90);
    step();
    chk("drain_c2_valid", 32'(if_hi.out_valid), 32'd1);
    chk("drain_c2_hi",    32'(if_hi.out_code),  32'd4);
    chk("drain_c2_lo",    32'(if_lo.out_code),  32'd4);
    step();
    chk("drain_c3_valid", 32'(if_lo.out_valid), 32'd1);
    chk("drain_c3_hi",    32'(if_hi.out_code),  32'd0);
    chk("drain_c3_lo",    32'(if_lo.out_code),  32'd7);
    step();
    chk("drain_end_hi",   32'(if_hi.out_valid), 32'd0);
    chk("drain_end_lo",   32'(if_lo.out_valid), 32'd0);

    // Backpressure: line 2 loads first and is not pre-empted by line 7.
    out_ready = 1'b0;
    req       = 8'h04;
    push_both(3'd2, 3'd2);
    push_both(3'd7, 3'd7);
    step();
    chk("bp_pend1", 32'(pend_hi), 32'h04);
    req = 8'h80;
    step();
    req = 8'h00;
    chk("bp_valid2", 32'(if_hi.out_valid), 32'd1);
    chk("bp_code2",  32'(if_hi.out_code),  32'd2);
    chk("bp_pend2",  32'(pend_hi),         32'h80);
    step();
    chk("bp_hold_code", 32'(if_hi.out_code),  32'd2);
    chk("bp_hold_pend", 32'(pend_lo),         32'h80);
    out_ready = 1'b1;
    step();
    chk("bp_code3", 32'(if_hi.out_code), 32'd7);
    chk("bp_pend3", 32'(pend_hi),        32'h00);
    step();
    chk("bp_end", 32'(if_hi.out_valid), 32'd0);

    // Set wins on the load edge, then overflow while stalled.
    req = 8'h08;
    push_both(3'd3, 3'd3);
    push_both(3'd3, 3'd3);
    step();
    chk("sw_pend1", 32'(pend_hi), 32'h08);
    step();
    chk("sw_code",  32'(if_hi.out_code), 32'd3);
    chk("sw_pend2", 32'(pend_hi),        32'h08);
    chk("sw_ovf",   32'(ovf_hi),         32'd0);
    out_ready = 1'b0;
    step();
    req = 8'h00;
    chk("ovf_set_hi", 32'(ovf_hi),  32'd1);
    chk("ovf_set_lo", 32'(ovf_lo),  32'd1);
    chk("ovf_pend",   32'(pend_hi), 32'h08);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_hi), 32'd0);
    out_ready = 1'b1;
    step();
    chk("sw_reload_valid", 32'(if_hi.out_valid), 32'd1);
    chk("sw_reload_pend",  32'(pend_hi),         32'h00);
    step();
    chk("sw_end", 32'(if_hi.out_valid), 32'd0);

    // Reset in the middle of operation discards everything.
    out_ready = 1'b0;
    req       = 8'hFF;
    step();
    step();
    chk("mid_pend_full", 32'(pend_hi),         32'hFF);
    chk("mid_valid",     32'(if_hi.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_hi.out_valid), 32'd0);
    chk("mid_rst_pend",  32'(pend_hi),         32'h00);
    chk("mid_rst_code",  32'(if_hi.out_code),  32'd0);
    chk("mid_rst_ovf",   32'(ovf_lo),          32'd0);
    req = 8'h00;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("post_rst_valid_hi", 32'(if_hi.out_valid), 32'd0);
    chk("post_rst_valid_lo", 32'(if_lo.out_valid), 32'd0);
    chk("post_rst_pend",     32'(pend_hi),         32'h00);
    step();

    chk("sb_hi_drained", 32'(exp_hi.size()), 32'd0);
    chk("sb_lo_drained", 32'(exp_lo.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
